write_buffer: RTL

Write-through store buffer between the L1 data cache and the main-memory controller. Absorbs the cache's write-through stores in a small FIFO so stores retire without waiting on DRAM, and drains them to memory in order. Passes cache read-miss fills through to memory, preserving read-after-write ordering. Can optionally forward buffered store data to a matching read.

---
 rtl/wbuf_pkg.sv | 30 +++
 rtl/wbuf_fifo.sv | 86 ++++++++
 rtl/write_buffer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/wbuf_pkg.sv
// Shared types and helpers for the write-through store buffer.
// WBUF_FORWARD_EN enables store-to-read forwarding in wbuf_fifo and write_buffer.
package wbuf_pkg;

  localparam int unsigned WBUF_DEPTH   = 4;
  localparam int unsigned WBUF_ADDR_W  = 32;
  localparam int unsigned WBUF_DATA_W  = 32;
  localparam int unsigned WBUF_MATCH_W = 64;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_DONE  = 3'd5
  } wbuf_state_e;

  // Occupancy counter must hold 0..depth inclusive.
  function automatic int unsigned wbuf_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Word-address compare; callers zero-extend addresses to WBUF_MATCH_W.
  function automatic logic word_match(input logic [WBUF_MATCH_W-1:0] a,
                                      input logic [WBUF_MATCH_W-1:0] b);
    return a[WBUF_MATCH_W-1:2] == b[WBUF_MATCH_W-1:2];
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Store FIFO: address/data storage, wrapping pointers, occupancy and flags.
// With WBUF_FORWARD_EN, a youngest-match lookup port over the valid entries.
module wbuf_fifo
  import wbuf_pkg::*;
#(
  parameter int unsigned DEPTH  = WBUF_DEPTH,
  parameter int unsigned ADDR_W = WBUF_ADDR_W,
  parameter int unsigned DATA_W = WBUF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
`ifdef WBUF_FORWARD_EN
  input  logic [ADDR_W-1:0] match_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = wbuf_cnt_w(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_addr = addr_mem[head_q];
  assign head_data = data_mem[head_q];

  // Pointers and count; reset discards all buffered entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) tail_q <= tail_q + PTR_W'(1);
      if (pop_ok)  head_q <= head_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset; validity comes from the count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[tail_q] <= push_addr;
      data_mem[tail_q] <= push_data;
    end
  end

`ifdef WBUF_FORWARD_EN
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) &&
          word_match(WBUF_MATCH_W'(addr_mem[head_q + PTR_W'(k)]),
                     WBUF_MATCH_W'(match_addr))) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[head_q + PTR_W'(k)];
      end
    end
  end
`endif

endmodule

// File: rtl/write_buffer.sv
// Write-through store buffer between L1 and the memory controller; drains stores in order.
// WBUF_FORWARD_EN: a pending read is served from the youngest matching buffered store.
module write_buffer
  import wbuf_pkg::*;
#(
  parameter int unsigned DEPTH  = WBUF_DEPTH,
  parameter int unsigned ADDR_W = WBUF_ADDR_W,
  parameter int unsigned DATA_W = WBUF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_busy,
  output logic [DATA_W-1:0] c_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_rdata
);

  wbuf_state_e       state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] c_rdata_d;
  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              push, pop, full, empty, rd_blk;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

`ifdef WBUF_FORWARD_EN
  logic              fwd_hit, fwd_ok;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_done_q, fwd_done_d;

  // Forward only before the read has gone to memory.
  assign fwd_ok = rd_pend_q & ~fwd_done_q & (state_q inside {IDLE, WR_ISSUE, WR_WAIT});
  assign rd_blk = fwd_hit | fwd_done_q;
`else
  assign rd_blk = 1'b0;
`endif

  assign push   = c_req & c_we & ~full;
  assign c_busy = full | rd_pend_q;

  wbuf_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (c_addr),
    .push_data  (c_wdata),
    .pop        (pop),
`ifdef WBUF_FORWARD_EN
    .match_addr (rd_addr_q),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
`endif
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      c_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef WBUF_FORWARD_EN
      fwd_done_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      c_rdata    <= c_rdata_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
`ifdef WBUF_FORWARD_EN
      fwd_done_q <= fwd_done_d;
`endif
    end
  end

  // Next state; mem_* are loaded on entry to the issue states and held through the wait.
  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rd_pend_q;
    rd_addr_d   = rd_addr_q;
    c_rdata_d   = c_rdata;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    pop         = 1'b0;
`ifdef WBUF_FORWARD_EN
    fwd_done_d  = 1'b0;
`endif

    if (c_req && !c_we && !rd_pend_q) begin
      rd_pend_d = 1'b1;
      rd_addr_d = c_addr;
    end

    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d     = WR_ISSUE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
        end else if (rd_pend_q && !rd_blk) begin
          state_d     = RD_ISSUE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = rd_addr_q;
        end
      end
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT: begin
        if (!mem_busy) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (!mem_busy) begin
          c_rdata_d = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = RD_DONE;
        end
      end
      RD_DONE: begin
        rd_pend_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef WBUF_FORWARD_EN
    // Load forwarded data one cycle, release the cache the next.
    if (fwd_done_q) begin
      rd_pend_d = 1'b0;
    end else if (fwd_ok && fwd_hit) begin
      c_rdata_d  = fwd_data;
      fwd_done_d = 1'b1;
    end
`endif
  end

endmodule
